// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART receiver.
//   state_t    - receiver FSM states
//   parity_t   - parity mode encoding (PAR_NONE / PAR_EVEN / PAR_ODD; 3 also means none)
//   sample_pt  - tick index of the k-th (0..2) majority sample inside a bit
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } state_t;

    typedef logic [1:0] parity_t;

    localparam parity_t PAR_NONE = 2'd0;
    localparam parity_t PAR_EVEN = 2'd1;
    localparam parity_t PAR_ODD  = 2'd2;

    // Three samples straddle the bit centre: OVS/2-1, OVS/2, OVS/2+1.
    function automatic int sample_pt(input int ovs, input int k);
        return ovs / 2 - 1 + k;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: valid/ready output channel of the UART receiver.
//   m_data  - received word, right-justified
//   m_perr  - parity error for m_data
//   m_ferr  - framing error for m_data
//   m_valid - holding register full
//   m_ready - consumer accepts the word
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
) ();

    logic [DBIT-1:0] m_data;
    logic            m_perr;
    logic            m_ferr;
    logic            m_valid;
    logic            m_ready;

    modport master (output m_data, m_perr, m_ferr, m_valid, input m_ready);
    modport slave  (input m_data, m_perr, m_ferr, m_valid, output m_ready);

endinterface

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: rx synchroniser plus three-sample majority voter.
//   clk, rst   - clock, asynchronous active-high reset
//   rx         - asynchronous serial line (idles high)
//   s_tick     - oversample strobe
//   s          - current tick index within the bit
//   sync_rx    - synchronised line level
//   vote       - majority of the three centre samples
//   vote_valid - high on the tick that takes the third sample (vote usable then)
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   s_tick,
    input  logic [$clog2(OVS)-1:0] s,
    output logic                   sync_rx,
    output logic                   vote,
    output logic                   vote_valid
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] P0 = SW'(sample_pt(OVS, 0));
    localparam logic [SW-1:0] P1 = SW'(sample_pt(OVS, 1));
    localparam logic [SW-1:0] P2 = SW'(sample_pt(OVS, 2));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   smp_a;
    logic                   smp_b;

    // NOTE: synchroniser flops reset to 1 so a reset line reads idle, not a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            smp_a  <= 1'b1;
            smp_b  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (s_tick && s == P0) smp_a <= sync_rx;
            if (s_tick && s == P1) smp_b <= sync_rx;
        end
    end

    assign sync_rx = sync_q[SYNC_STAGES-1];

    // Third sample is taken live so the vote is ready on the decision tick itself.
    assign vote       = (smp_a & smp_b) | (smp_a & sync_rx) | (smp_b & sync_rx);
    assign vote_valid = s_tick && (s == P2);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable oversampling UART receiver.
//   clk, rst    - clock, asynchronous active-high reset
//   rx          - serial line (idles high)
//   s_tick      - oversample strobe, OVS per bit
//   cfg_dbits   - data bits (5..DBIT, else DBIT), latched at start edge
//   cfg_parity  - 0/3 none, 1 even, 2 odd, latched at start edge
//   cfg_stop2   - two stop bits when 1, latched at start edge
//   m_if        - valid/ready output holding register (master side)
//   overrun     - pulse: a completed frame was dropped
//   break_det   - pulse: break detected
//   busy        - FSM not idle
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        s_tick,
    input  logic [3:0]  cfg_dbits,
    input  logic [1:0]  cfg_parity,
    input  logic        cfg_stop2,
    uart_rx_cfg_if.master m_if,
    output logic        overrun,
    output logic        break_det,
    output logic        busy
);

    localparam int SW = $clog2(OVS);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);

    logic            sync_rx;
    logic            vote;
    logic            vote_valid;
    logic            bit_end;
    logic [3:0]      dbits_eff;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [NW-1:0]   n_last;
    parity_t         par_q;
    logic            stop2_q;
    logic            stop_idx;
    logic [DBIT-1:0] shreg;
    logic            perr_q;
    logic            ferr_q;
    logic            all_zero;

    uart_bit_sampler #(
        .OVS         (OVS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .s_tick     (s_tick),
        .s          (s),
        .sync_rx    (sync_rx),
        .vote       (vote),
        .vote_valid (vote_valid)
    );

    assign bit_end = s_tick && (s == S_LAST);

    always_comb begin
        dbits_eff = cfg_dbits;
        if (cfg_dbits < 4'd5 || cfg_dbits > 4'(DBIT)) dbits_eff = 4'(DBIT);
    end

    // NOTE: all state uses non-blocking assignments; pulses are defaulted low first
    // and later assignments in the same pass override the default.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            s           <= '0;
            n           <= '0;
            n_last      <= '0;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            all_zero    <= 1'b0;
            m_if.m_data <= '0;
            m_if.m_perr <= 1'b0;
            m_if.m_ferr <= 1'b0;
            m_if.m_valid <= 1'b0;
            overrun     <= 1'b0;
            break_det   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (m_if.m_valid && m_if.m_ready) m_if.m_valid <= 1'b0;

            if (state != ST_IDLE && s_tick) s <= (s == S_LAST) ? '0 : s + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!sync_rx) begin
                        state    <= ST_START;
                        busy     <= 1'b1;
                        s        <= '0;
                        n_last   <= NW'(dbits_eff - 4'd1);
                        par_q    <= (cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD) ? cfg_parity : PAR_NONE;
                        stop2_q  <= cfg_stop2;
                        stop_idx <= 1'b0;
                        shreg    <= '0;
                        perr_q   <= 1'b0;
                        ferr_q   <= 1'b0;
                        all_zero <= 1'b1;
                    end
                end
                ST_START: begin
                    if (vote_valid && vote) begin
                        state <= ST_IDLE;   // false start: glitch shorter than half a bit
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                        n     <= '0;
                    end
                end
                ST_DATA: begin
                    if (vote_valid) begin
                        shreg    <= shreg | (DBIT'(vote) << n);
                        all_zero <= all_zero & ~vote;
                    end
                    if (bit_end) begin
                        if (n == n_last) state <= (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        else             n     <= n + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (vote_valid) begin
                        perr_q   <= (par_q == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                        all_zero <= all_zero & ~vote;
                    end
                    if (bit_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (vote_valid) begin
                        if (!stop_idx && all_zero && !vote) begin
                            break_det <= 1'b1;
                            state     <= ST_BRK_WAIT;
                        end else if (stop_idx == stop2_q) begin
                            // Final stop decided at its centre; return early to catch the next edge.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            if (!m_if.m_valid || m_if.m_ready) begin
                                m_if.m_data  <= shreg;
                                m_if.m_perr  <= perr_q;
                                m_if.m_ferr  <= ferr_q | ~vote;
                                m_if.m_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            ferr_q <= ferr_q | ~vote;
                        end
                    end
                    if (bit_end) stop_idx <= 1'b1;
                end
                ST_BRK_WAIT: begin
                    if (sync_rx) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed self-checking bench for uart_rx_cfg (DBIT=8, OVS=16).
// Inputs are driven 1 time unit after the rising edge; outputs are observed
// either at that point or by a monitor on the falling edge.
module tb_uart_rx_cfg;

    localparam int TICK_GAP = 3;   // idle clocks between s_tick pulses

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'd0;
    logic       cfg_stop2 = 1'b0;
    logic       overrun;
    logic       break_det;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int acc_count = 0;
    int ovr_count = 0;
    int brk_count = 0;
    int vld_count = 0;

    uart_rx_cfg_if #(.DBIT(8)) m_if ();

    uart_rx_cfg #(.DBIT(8), .OVS(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .s_tick     (s_tick),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .m_if       (m_if.master),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.m_valid && m_if.m_ready) acc_count++;
            if (m_if.m_valid) vld_count++;
            if (overrun) ovr_count++;
            if (break_det) brk_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            s_tick = 1'b0;
            repeat (TICK_GAP) step();
            s_tick = 1'b1;
            step();
        end
        s_tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick_n(16);
    endtask

    // Sends a frame up to the decision tick (10th) of its final stop bit.
    task automatic send_frame(input logic [8:0] d, input int nb, input int par,
                              input logic st1, input logic st2, input bit two);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (par >= 0) send_bit(par[0]);
        if (two) begin
            send_bit(st1);
            rx = st2;
        end else begin
            rx = st1;
        end
        tick_n(10);
    endtask

    task automatic finish_frame();
        tick_n(6);
        rx = 1'b1;
        tick_n(32);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_if.m_ready = 1'b1;
        repeat (3) step();
        n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_if.m_valid); end
        n_checks++; if (m_if.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", m_if.m_data); end
        n_checks++; if ({m_if.m_perr, m_if.m_ferr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {m_if.m_perr, m_if.m_ferr}); end
        n_checks++; if ({overrun, break_det, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {overrun, break_det, busy}); end
        rst = 1'b0;
        tick_n(8);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_8n1();
        int a0;
        a0 = acc_count;
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        send_frame(9'h0A5, 8, -1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL 8n1_latency_valid: got %b expected 1", m_if.m_valid); end
        n_checks++; if (m_if.m_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h expected a5", m_if.m_data); end
        n_checks++; if ({m_if.m_perr, m_if.m_ferr} !== 2'b00) begin n_fail++; $display("FAIL 8n1_flags: got %b expected 00", {m_if.m_perr, m_if.m_ferr}); end
        finish_frame();
        n_checks++; if (acc_count - a0 !== 1) begin n_fail++; $display("FAIL 8n1_one_word: got %0d expected 1", acc_count - a0); end
    endtask

    task automatic test_7e1_bad_parity();
        cfg_dbits = 4'd7; cfg_parity = 2'd1; cfg_stop2 = 1'b0;
        send_frame(9'h041, 7, 1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (m_if.m_data !== 8'h41) begin n_fail++; $display("FAIL 7e1_data: got %h expected 41", m_if.m_data); end
        n_checks++; if (m_if.m_perr !== 1'b1) begin n_fail++; $display("FAIL 7e1_perr: got %b expected 1", m_if.m_perr); end
        n_checks++; if (m_if.m_ferr !== 1'b0) begin n_fail++; $display("FAIL 7e1_ferr: got %b expected 0", m_if.m_ferr); end
        finish_frame();
    endtask

    task automatic test_8o2_bad_stop();
        cfg_dbits = 4'd8; cfg_parity = 2'd2; cfg_stop2 = 1'b1;
        send_frame(9'h03C, 8, 1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (m_if.m_data !== 8'h3C) begin n_fail++; $display("FAIL 8o2_data: got %h expected 3c", m_if.m_data); end
        n_checks++; if ({m_if.m_perr, m_if.m_ferr} !== 2'b01) begin n_fail++; $display("FAIL 8o2_flags: got %b expected 01", {m_if.m_perr, m_if.m_ferr}); end
        finish_frame();
    endtask

    task automatic test_false_start();
        int a0;
        a0 = acc_count;
        cfg_dbits = 4'd15; cfg_parity = 2'd3; cfg_stop2 = 1'b0;   // out-of-range -> 8 bits, 3 -> none
        rx = 1'b0;
        tick_n(2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
        tick_n(2);
        rx = 1'b1;
        tick_n(6);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_abort: got %b expected 0", busy); end
        tick_n(16);
        n_checks++; if (acc_count - a0 !== 0) begin n_fail++; $display("FAIL glitch_no_word: got %0d expected 0", acc_count - a0); end
        send_frame(9'h055, 8, -1, 1'b1, 1'b1, 1'b0);
        n_checks++; if ({m_if.m_valid, m_if.m_data} !== 9'h155) begin n_fail++; $display("FAIL glitch_next_frame: got %h expected 155", {m_if.m_valid, m_if.m_data}); end
        finish_frame();
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        a0 = acc_count; o0 = ovr_count;
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        m_if.m_ready = 1'b0;
        send_frame(9'h011, 8, -1, 1'b1, 1'b1, 1'b0);
        tick_n(6);
        send_frame(9'h022, 8, -1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun_pulse: got %b expected 1", overrun); end
        finish_frame();
        n_checks++; if (m_if.m_data !== 8'h11) begin n_fail++; $display("FAIL b2b_held_data: got %h expected 11", m_if.m_data); end
        n_checks++; if (m_if.m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_held_valid: got %b expected 1", m_if.m_valid); end
        n_checks++; if (ovr_count - o0 !== 1) begin n_fail++; $display("FAIL b2b_overrun_count: got %0d expected 1", ovr_count - o0); end
        m_if.m_ready = 1'b1;
        step();
        n_checks++; if (m_if.m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b expected 0", m_if.m_valid); end
        n_checks++; if (acc_count - a0 !== 1) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 1", acc_count - a0); end
    endtask

    task automatic test_break();
        int a0, b0, v0;
        a0 = acc_count; b0 = brk_count; v0 = vld_count;
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        rx = 1'b0;
        tick_n(320);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL brk_wait_busy: got %b expected 1", busy); end
        rx = 1'b1;
        tick_n(32);
        n_checks++; if (brk_count - b0 !== 1) begin n_fail++; $display("FAIL brk_pulse_count: got %0d expected 1", brk_count - b0); end
        n_checks++; if (vld_count - v0 !== 0) begin n_fail++; $display("FAIL brk_no_valid: got %0d expected 0", vld_count - v0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL brk_idle: got %b expected 0", busy); end
        send_frame(9'h07E, 8, -1, 1'b1, 1'b1, 1'b0);
        n_checks++; if ({m_if.m_valid, m_if.m_data} !== 9'h17E) begin n_fail++; $display("FAIL brk_next_frame: got %h expected 17e", {m_if.m_valid, m_if.m_data}); end
        finish_frame();
        n_checks++; if (acc_count - a0 !== 1) begin n_fail++; $display("FAIL brk_accepts: got %0d expected 1", acc_count - a0); end
    endtask

    task automatic test_vote_glitch();
        cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rx = 1'b0; tick_n(8);
        rx = 1'b1; tick_n(1);     // inverted only for the s=OVS/2 sample of bit 3
        rx = 1'b0; tick_n(7);
        for (int i = 4; i < 8; i++) send_bit(1'b0);
        rx = 1'b1;
        tick_n(10);
        n_checks++; if ({m_if.m_valid, m_if.m_data} !== 9'h100) begin n_fail++; $display("FAIL vote_data: got %h expected 100", {m_if.m_valid, m_if.m_data}); end
        n_checks++; if ({m_if.m_perr, m_if.m_ferr} !== 2'b00) begin n_fail++; $display("FAIL vote_flags: got %b expected 00", {m_if.m_perr, m_if.m_ferr}); end
        finish_frame();
    endtask

    task automatic test_reset_midframe();
        int a0;
        a0 = acc_count;
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        tick_n(5);
        rst = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        rx = 1'b1;
        tick_n(48);
        n_checks++; if ({m_if.m_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_quiet: got %b expected 00", {m_if.m_valid, busy}); end
        n_checks++; if (acc_count - a0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_word: got %0d expected 0", acc_count - a0); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1_bad_parity();
        test_8o2_bad_stop();
        test_false_start();
        test_back_to_back();
        test_break();
        test_vote_glitch();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
